// File: rtl/bidir_io_debounce.sv
// Debounce and edge-detect stage for an already-synchronized pad level.
// Publishes a clean level, rise/fall/glitch strobes and a saturating rise count.
module bidir_io_debounce #(
    parameter int   STABLE_CYC = 4,
    parameter logic INIT_LEVEL = 1'b0,
    parameter int   EVT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             en,
    input  logic             clr,
    output logic             dout,
    output logic             rise,
    output logic             fall,
    output logic             glitch,
    output logic             busy,
    output logic [EVT_W-1:0] evt_cnt
);
    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);

    typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} state_t;
    localparam state_t RST_STATE = INIT_LEVEL ? STABLE_HI : STABLE_LO;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             dout_nxt, rise_nxt, fall_nxt, glitch_nxt;
    logic [EVT_W-1:0] evt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RST_STATE;
            cnt     <= '0;
            dout    <= INIT_LEVEL;
            rise    <= 1'b0;
            fall    <= 1'b0;
            glitch  <= 1'b0;
            evt_cnt <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            dout    <= dout_nxt;
            rise    <= rise_nxt;
            fall    <= fall_nxt;
            glitch  <= glitch_nxt;
            evt_cnt <= evt_nxt;
        end
    end

    // cnt holds the number of samples already seen at the pending level
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (en) begin
            case (state)
                STABLE_LO: if (din) begin
                    state_nxt = PEND_HI;
                    cnt_nxt   = CW'(1);
                end
                PEND_HI: begin
                    if (!din) begin
                        state_nxt = STABLE_LO;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = STABLE_HI;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                STABLE_HI: if (!din) begin
                    state_nxt = PEND_LO;
                    cnt_nxt   = CW'(1);
                end
                PEND_LO: begin
                    if (din) begin
                        state_nxt = STABLE_HI;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = STABLE_LO;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = RST_STATE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        rise_nxt   = en && (state == PEND_HI) && din && (cnt == CNT_LAST);
        fall_nxt   = en && (state == PEND_LO) && !din && (cnt == CNT_LAST);
        glitch_nxt = en && (((state == PEND_HI) && !din) || ((state == PEND_LO) && din));
        dout_nxt   = dout;
        if (rise_nxt) dout_nxt = 1'b1;
        if (fall_nxt) dout_nxt = 1'b0;
        // clear beats a coincident rise; count sticks at all-ones
        evt_nxt = evt_cnt;
        if (clr)
            evt_nxt = '0;
        else if (rise_nxt && (evt_cnt != {EVT_W{1'b1}}))
            evt_nxt = evt_cnt + 1'b1;
        busy = (state == PEND_HI) || (state == PEND_LO);
    end
endmodule

// File: tb/tb_bidir_io_debounce.sv
// Self-checking bench: vector table fed through an expected-value queue, plus
// a hand-written reset-while-pending sequence on an INIT_LEVEL=1 instance.
module tb_bidir_io_debounce;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, din, en, clr;
    logic       dout, rise, fall, glitch, busy;
    logic [1:0] evt_cnt;

    logic       rst1_n, din1, en1, clr1;
    logic       dout1, rise1, fall1, glitch1, busy1;
    logic [7:0] evt1;

    bidir_io_debounce #(.STABLE_CYC(4), .INIT_LEVEL(1'b0), .EVT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clr(clr),
        .dout(dout), .rise(rise), .fall(fall), .glitch(glitch),
        .busy(busy), .evt_cnt(evt_cnt)
    );

    bidir_io_debounce #(.STABLE_CYC(4), .INIT_LEVEL(1'b1), .EVT_W(8)) dut1 (
        .clk(clk), .rst_n(rst1_n), .din(din1), .en(en1), .clr(clr1),
        .dout(dout1), .rise(rise1), .fall(fall1), .glitch(glitch1),
        .busy(busy1), .evt_cnt(evt1)
    );

    typedef struct {
        logic din, en, clr;
        logic dout, rise, fall, glitch, busy;
        int   evt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic add(input logic d, e, c, o, r, f, g, b, input int ev);
        vec_t v;
        v.din = d; v.en = e; v.clr = c;
        v.dout = o; v.rise = r; v.fall = f; v.glitch = g; v.busy = b; v.evt = ev;
        vecs.push_back(v);
    endtask

    // Three pending samples then the accepting fourth one (STABLE_CYC=4)
    task automatic add_change(input logic lvl, input int ev_before, input int ev_after,
                              input logic clr_last);
        for (int k = 0; k < 3; k++) add(lvl, 1, 0, !lvl, 0, 0, 0, 1, ev_before);
        add(lvl, 1, clr_last, lvl, lvl, !lvl, 0, 0, ev_after);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        vec_t v, e;
        int   ev;
        rst_n = 1'b0; din = 1'b0; en = 1'b0; clr = 1'b0;
        rst1_n = 1'b0; din1 = 1'b1; en1 = 1'b1; clr1 = 1'b0;

        // clean rise, then fall
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        add_change(1, 0, 1, 0);
        add(1, 1, 0, 1, 0, 0, 0, 0, 1);
        add_change(0, 1, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 1);
        // 3-sample pulse is rejected
        for (int k = 0; k < 3; k++) add(1, 1, 0, 0, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0, 0, 0, 1, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 1);
        // en=0 for four edges stretches acceptance
        add(1, 1, 0, 0, 0, 0, 0, 1, 1);
        for (int k = 0; k < 4; k++) add(1, 0, 0, 0, 0, 0, 0, 1, 1);
        add(1, 1, 0, 0, 0, 0, 0, 1, 1);
        add(1, 1, 0, 0, 0, 0, 0, 1, 1);
        add(1, 1, 0, 1, 1, 0, 0, 0, 2);
        add(1, 0, 0, 1, 0, 0, 0, 0, 2);
        // rises 3..5 saturate the 2-bit counter
        ev = 2;
        for (int n = 3; n <= 5; n++) begin
            add_change(0, ev, ev, 0);
            add_change(1, ev, (n > 3) ? 3 : n, 0);
            ev = (n > 3) ? 3 : n;
        end
        // sixth rise with clr on the same edge
        add_change(0, 3, 3, 0);
        add_change(1, 3, 0, 1);
        add_change(0, 0, 0, 0);
        add_change(1, 0, 1, 0);
        add(1, 0, 1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0, 0, 0);

        #1;
        chk("reset_outs", {dout, rise, fall, glitch, busy}, 5'b0);
        chk("reset_evt", 32'(evt_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            v = vecs[i];
            din = v.din; en = v.en; clr = v.clr;
            sb.push_back(v);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_chk++;
            if ({dout, rise, fall, glitch, busy} !== {e.dout, e.rise, e.fall, e.glitch, e.busy}
                || 32'(evt_cnt) != e.evt) begin
                n_fail++;
                $display("FAIL vec%0d: got d/r/f/g/b=%b evt=%0d expected %b evt=%0d", i,
                         {dout, rise, fall, glitch, busy}, evt_cnt,
                         {e.dout, e.rise, e.fall, e.glitch, e.busy}, e.evt);
            end
        end

        // INIT_LEVEL=1: reset while a fall is pending
        chk("init1_reset_dout", 32'(dout1), 1);
        @(negedge clk);
        rst1_n = 1'b1;
        @(posedge clk); #1;
        chk("init1_idle", {dout1, busy1, fall1}, 3'b100);
        @(negedge clk);
        din1 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("init1_pend", {dout1, busy1, fall1}, 3'b110);
        end
        #1;
        rst1_n = 1'b0;
        #1;
        chk("async_rst_outs", {dout1, busy1, fall1, rise1, glitch1}, 5'b10000);
        chk("async_rst_evt", 32'(evt1), 0);
        @(negedge clk);
        rst1_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_no_fall", {dout1, busy1, fall1}, 3'b110);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("post_rst_pend", {dout1, busy1, fall1}, 3'b110);
        end
        @(posedge clk); #1;
        chk("init1_fall", {dout1, busy1, fall1}, 3'b001);
        @(posedge clk); #1;
        chk("init1_fall_once", {dout1, busy1, fall1}, 3'b000);
        chk("init1_evt", 32'(evt1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bidir_io_debounce.md
# bidir_io_debounce

Debounce and edge-detect stage that sits directly downstream of the bidirectional pad synchronizer. It consumes the already-synchronized pad level and qualifies it with a stability counter. It then publishes a clean level, single-cycle rise/fall/glitch strobes and a saturating rising-edge event count to core logic.

## Interface
- STABLE_CYC, default 4: consecutive identical samples required to accept a new level; legal range 2..65535.
- INIT_LEVEL, default 1'b0: level assumed out of reset.
- EVT_W, default 8: width of the event counter.

- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low; one clock, asynchronous active-low reset.
- din  input  1  synchronized pad level from the pad synchronizer output; no further sync performed here.
- en  input  1  sample enable; 0 freezes FSM, counter and strobes.
- clr  input  1  synchronous clear of evt_cnt.
- dout  output  1  debounced level, registered.
- rise  output  1  one-cycle strobe, registered: dout went 0->1.
- fall  output  1  one-cycle strobe, registered: dout went 1->0.
- glitch  output  1  one-cycle strobe, registered: pending change rejected.
- busy  output  1  high while a level change is pending (decoded from state register).
- evt_cnt  output  EVT_W  count of rise strobes, saturating.

## Operation
- FSM states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO. Stability counter cnt has width clog2(STABLE_CYC+1).
- Reset (rst_n=0, async): state = STABLE_HI if INIT_LEVEL else STABLE_LO; cnt=0; dout=INIT_LEVEL; rise=fall=glitch=0; evt_cnt=0; busy=0.
- All transitions below occur only when en=1. When en=0, state, cnt, dout and evt_cnt hold (clr still acts), and rise/fall/glitch are 0.
- STABLE_LO:
  - din=1 -> PEND_HI, cnt=1.
  - din=0 -> stay.
- PEND_HI:
  - din=0 -> STABLE_LO, cnt=0, glitch=1.
  - din=1 and cnt==STABLE_CYC-1 -> STABLE_HI, cnt=0, dout=1, rise=1.
  - din=1 otherwise -> cnt+1.
- STABLE_HI / PEND_LO: mirror image. PEND_LO accepts into STABLE_LO with dout=0 and fall=1; rejection returns to STABLE_HI with glitch=1.
- evt_cnt:
  - Increments by 1 on each cycle the rise strobe is being set.
  - Saturates at 2^EVT_W-1; no wrap.
  - clr=1 sets it to 0 regardless of en.
  - clr and rise in the same cycle: clr wins, result 0.
- Strobes are never set for more than one consecutive cycle. rise and fall are never high together.
- busy = (state==PEND_HI || state==PEND_LO).

## Timing
- Acceptance latency: if din is first sampled at the new level on edge k and held, dout changes after edge k+STABLE_CYC-1. rise/fall assert in that same cycle.
- A pulse of fewer than STABLE_CYC consecutive sampled cycles never changes dout. glitch asserts after the edge that samples the reversion.
- Cycles with en=0 do not count toward STABLE_CYC and do not break a pending sequence.
- Reset mid-pending: the pending change is discarded, outputs take reset values immediately (asynchronous), and no strobe is emitted on reset release.
- After reset release, the first edge with en=1 is treated as a normal sample against INIT_LEVEL.
- evt_cnt updates on the same edge that sets rise, so it is visible alongside the strobe.

## Test plan
- Reset/init: INIT_LEVEL=1, assert rst_n=0 mid-PEND_LO -> dout=1, busy=0, evt_cnt=0 immediately; no fall strobe after release.
- Clean edge: STABLE_CYC=4, din 0->1 at edge 10, held -> dout=1 and rise=1 after edge 13 only; evt_cnt=1 after edge 13.
- Glitch rejection: din high for 3 edges (10..12), low at 13 -> dout stays 0, glitch=1 after edge 13, busy 1 during edges 10..12, evt_cnt unchanged.
- Enable freeze: din high from edge 10, en=0 at edges 11..14 -> dout rises after edge 17, not 13.
- Saturation and clr priority: EVT_W=2, produce 5 accepted rises -> evt_cnt reads 1,2,3,3,3. Then clr=1 on the same edge as a 6th rise -> evt_cnt=0, rise=1.
- Fall path: from STABLE_HI, din low 4 edges -> dout=0, fall=1 for exactly one cycle, evt_cnt unchanged.
